// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap/saturate, sync clear/load and a registered terminal-count pulse.
// Define COUNTER_AUTOREPEAT_EN to treat en as a held button level driving an auto-repeat engine.
module updown_mod_counter #(
   parameter int WIDTH        = 4,
   parameter int MAX_VAL      = 15,
   parameter int REPEAT_DELAY = 24,
   parameter int REPEAT_RATE  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             sat,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             at_max,
   output logic             at_min
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

   logic             step;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;

`ifdef COUNTER_AUTOREPEAT_EN
   localparam int CycMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CW     = $clog2(CycMax + 1);
   localparam logic [CW-1:0] DelayLast = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RateLast  = CW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

   state_t          state_q;
   logic [CW-1:0]   cyc_q;
   logic            enPrev_q;

   always_comb begin
      step = 1'b0;
      unique case (state_q)
         IDLE:    step = en && !enPrev_q;
         DELAY:   step = en && (cyc_q == DelayLast);
         REPEAT:  step = en && (cyc_q == RateLast);
         default: step = 1'b0;
      endcase
   end

   // enPrev_q comes out of reset high so a button held through reset needs a re-press;
   // clr/load copy en into it for the same reason.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cyc_q    <= '0;
         enPrev_q <= 1'b1;
      end else begin
         enPrev_q <= en;
         if (clr || load || !en) begin
            state_q <= IDLE;
            cyc_q   <= '0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (step) begin
                     state_q <= DELAY;
                     cyc_q   <= '0;
                  end
               end
               DELAY: begin
                  if (step) begin
                     state_q <= REPEAT;
                     cyc_q   <= '0;
                  end else begin
                     cyc_q <= cyc_q + 1'b1;
                  end
               end
               REPEAT: begin
                  cyc_q <= step ? '0 : cyc_q + 1'b1;
               end
               default: begin
                  state_q <= IDLE;
                  cyc_q   <= '0;
               end
            endcase
         end
      end
   end
`else
   logic armed_q;

   // After reset, en must be seen low once before strobes are accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed_q <= 1'b0;
      end else if (!en) begin
         armed_q <= 1'b1;
      end
   end

   assign step = en && armed_q;
`endif

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = (load_val > MaxVal) ? MaxVal : load_val;
      end else if (step) begin
         if (up) begin
            if (count_q == MaxVal) begin
               tc_d    = 1'b1;
               count_d = sat ? count_q : '0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (count_q == '0) begin
               tc_d    = 1'b1;
               count_d = sat ? count_q : MaxVal;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign count  = count_q;
   assign tc     = tc_q;
   assign at_max = (count_q == MaxVal);
   assign at_min = (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter: directed vectors, literal checks, and a
// per-cycle comparison against an arithmetic model. Honours COUNTER_AUTOREPEAT_EN.
module tb_updown_mod_counter;

   localparam int WIDTH = 4;
   localparam int MAXV  = 9;
   localparam int RD    = 4;
   localparam int RR    = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0, up = 1'b1, sat = 1'b0, clr = 1'b0, load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic [WIDTH-1:0] count;
   logic             tc, at_max, at_min;

   int total = 0;
   int bad   = 0;

   updown_mod_counter #(
      .WIDTH(WIDTH), .MAX_VAL(MAXV), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
      .load_val(load_val), .count(count), .tc(tc), .at_max(at_max), .at_min(at_min)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: count as plain integer, plus press-tracking for step generation.
   int mCount = 0;
   bit mTc = 0;
   bit mArmed = 0;
   bit mPrevEn = 1;
   int holdIdx = -1;

   // The model applies the counting rules once per rising edge using the sampled inputs.
   always @(posedge clk or posedge rst) begin
      bit s;
      if (rst) begin
         mCount = 0; mTc = 0; mArmed = 0; mPrevEn = 1; holdIdx = -1;
      end else begin
         s = 0;
`ifdef COUNTER_AUTOREPEAT_EN
         if (clr || load || !en) begin
            holdIdx = -1;
         end else if (holdIdx < 0) begin
            if (!mPrevEn) begin
               holdIdx = 0;
               s = 1;
            end
         end else begin
            holdIdx++;
            s = (holdIdx == RD) || (holdIdx > RD && ((holdIdx - RD) % RR) == 0);
         end
         mPrevEn = en;
`else
         s = en && mArmed;
         if (!en) mArmed = 1;
`endif
         mTc = 0;
         if (clr) begin
            mCount = 0;
         end else if (load) begin
            mCount = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
         end else if (s) begin
            if (up) begin
               if (mCount == MAXV) begin
                  mTc = 1;
                  if (!sat) mCount = 0;
               end else mCount = mCount + 1;
            end else begin
               if (mCount == 0) begin
                  mTc = 1;
                  if (!sat) mCount = MAXV;
               end else mCount = mCount - 1;
            end
         end
      end
   end

   // Compare every cycle away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("model_count", 32'(count), 32'(mCount));
         check("model_tc", 32'(tc), 32'(mTc));
         check("model_at_max", 32'(at_max), 32'(mCount == MAXV));
         check("model_at_min", 32'(at_min), 32'(mCount == 0));
      end
   end

   task automatic applyStimulus(input logic e, input logic u, input logic s, input logic c,
                                input logic l, input logic [WIDTH-1:0] lv);
      @(negedge clk);
      en = e; up = u; sat = s; clr = c; load = l; load_val = lv;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int expCount, input int expTc);
      check({name, "_count"}, 32'(count), 32'(expCount));
      check({name, "_tc"}, 32'(tc), 32'(expTc));
   endtask

   task automatic pulse(input logic u, input logic s);
      applyStimulus(1, u, s, 0, 0, '0);
   endtask

   task automatic idle(input logic u, input logic s);
      applyStimulus(0, u, s, 0, 0, '0);
   endtask

   initial begin
      #12;
      checkOutput("reset", 0, 0);
      check("reset_at_min", 32'(at_min), 1);
      check("reset_at_max", 32'(at_max), 0);
      @(negedge clk);
      rst = 1'b0;
      idle(1, 0);

      // Wrap upward through MAX_VAL
      for (int i = 1; i <= 10; i++) begin
         pulse(1, 0);
         checkOutput($sformatf("up_wrap%0d", i), i % 10, (i == 10) ? 1 : 0);
         check($sformatf("up_wrap%0d_at_max", i), 32'(at_max), (i == 9) ? 1 : 0);
         idle(1, 0);
         check($sformatf("up_wrap%0d_tc_drop", i), 32'(tc), 0);
      end

      // Wrap downward through zero
      pulse(0, 0);
      checkOutput("down_wrap", 9, 1);
      idle(0, 0);
      pulse(0, 0);
      checkOutput("down_step", 8, 0);
      idle(0, 0);

      // Saturation at the top, then step back down
      applyStimulus(0, 1, 1, 0, 1, 4'd9);
      checkOutput("load9", 9, 0);
      for (int i = 0; i < 3; i++) begin
         pulse(1, 1);
         checkOutput($sformatf("sat_hold%0d", i), 9, 1);
         idle(1, 1);
      end
      pulse(0, 1);
      checkOutput("sat_down", 8, 0);
      idle(0, 1);
      applyStimulus(0, 0, 1, 1, 0, '0);
      pulse(0, 1);
      checkOutput("sat_bottom", 0, 1);
      idle(1, 0);

      // Load clamping and priority
      applyStimulus(0, 1, 0, 0, 1, 4'd13);
      checkOutput("load_clamp", 9, 0);
      applyStimulus(1, 1, 0, 1, 1, 4'd5);
      checkOutput("clr_prio", 0, 0);
      idle(1, 0);
      applyStimulus(1, 1, 0, 0, 1, 4'd3);
      checkOutput("load_over_step", 3, 0);
      idle(1, 0);

      // Asynchronous reset mid-cycle with en held
      applyStimulus(0, 1, 0, 0, 1, 4'd5);
      checkOutput("load5", 5, 0);
      applyStimulus(1, 1, 0, 0, 0, '0);
      checkOutput("pre_reset_step", 6, 0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset", 0, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 0, 0, '0);
         checkOutput($sformatf("held_after_reset%0d", i), 0, 0);
      end
      idle(1, 0);
      pulse(1, 0);
      checkOutput("repress_after_reset", 1, 0);
      idle(1, 0);
      applyStimulus(0, 1, 0, 1, 0, '0);

`ifdef COUNTER_AUTOREPEAT_EN
      // Held button: steps on edges 1, 5, 7 and 9
      begin
         int expSeq[10] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};
         for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 0, 0, 0, '0);
            checkOutput($sformatf("repeat_edge%0d", i + 1), expSeq[i], 0);
         end
      end
      for (int i = 0; i < 3; i++) begin
         idle(1, 0);
         checkOutput($sformatf("released%0d", i), 4, 0);
      end
      pulse(1, 0);
      checkOutput("repress", 5, 0);
      applyStimulus(1, 1, 0, 1, 0, '0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 1, 0, 0, 0, '0);
         checkOutput($sformatf("held_after_clr%0d", i), 0, 0);
      end
      idle(1, 0);
`else
      // Held strobe steps every cycle
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1, 1, 0, 0, 0, '0);
         checkOutput($sformatf("strobe_held%0d", i), i, 0);
      end
      idle(1, 0);
`endif

      repeat (2) idle(1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
